// File: rtl/pulse_level_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | pulse_level_pkg                                                  |
// | Shared state encoding and helpers for the pulse-to-level block.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pulse_level_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_idle     = 2'b00;
    localparam state_t c_hold     = 2'b01;
    localparam state_t c_wait_ack = 2'b11;
    localparam state_t c_gap      = 2'b10;

    function automatic int pend_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_updown_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sat_updown_counter                                               |
// | Saturating up/down event counter with a sticky lost-event flag.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sat_updown_counter
    import pulse_level_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             lost
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(pend_max(WIDTH));

    logic [WIDTH-1:0] r_count;
    logic             r_lost;

    // Simultaneous inc and dec cancel, so a same-cycle consume never loses an event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_lost  <= 1'b0;
        end else if (inc && !dec) begin
            if (r_count == c_max) begin
                r_lost <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign lost  = r_lost;

endmodule
`default_nettype wire

// File: rtl/pulse_to_level.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | pulse_to_level                                                   |
// | Turns single-cycle event pulses into held, acknowledged requests.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pulse_to_level
    import pulse_level_pkg::*;
#(
    parameter int MIN_HIGH = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic             ack,
    output logic             level,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int                  c_hold_w    = (MIN_HIGH > 1) ? $clog2(MIN_HIGH) : 1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(MIN_HIGH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_hold_w-1:0] w_hold_cnt_nxt;
    logic                r_level;
    logic                w_consume;
    logic                w_inc;
    logic                w_hold_done;

    assign w_consume = (r_state == c_wait_ack) && ack && ((pending != '0) || pulse);
    assign w_inc     = pulse && (r_state != c_idle);

    // Leaving HOLD on the last count makes WAIT_ACK the MIN_HIGH-th high cycle,
    // so an ack there ends a request of exactly MIN_HIGH cycles.
    assign w_hold_done = (r_hold_cnt <= c_hold_w'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            c_idle: begin
                if (pulse) begin
                    w_state_nxt    = c_hold;
                    w_hold_cnt_nxt = c_hold_load;
                end
            end
            c_hold: begin
                if (w_hold_done) begin
                    w_state_nxt    = c_wait_ack;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end
            end
            c_wait_ack: begin
                if (ack) begin
                    w_state_nxt = w_consume ? c_gap : c_idle;
                end
            end
            c_gap: begin
                w_state_nxt    = c_hold;
                w_hold_cnt_nxt = c_hold_load;
            end
            default: begin
                w_state_nxt    = c_idle;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_idle;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_level    <= (w_state_nxt == c_hold) || (w_state_nxt == c_wait_ack);
        end
    end

    sat_updown_counter #(
        .WIDTH (CNT_W)
    ) u_pending (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc),
        .dec   (w_consume),
        .count (pending),
        .lost  (overflow)
    );

    assign level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pulse_to_level.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pulse_to_level                                                |
// | Scoreboard bench: request-level reference model vs. the DUT.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pulse_to_level;

    localparam int MIN_HIGH = 4;
    localparam int CNT_W    = 2;
    localparam int PMAX     = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             pulse = 1'b0;
    logic             ack   = 1'b0;
    logic             level;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    pulse_to_level #(
        .MIN_HIGH (MIN_HIGH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse    (pulse),
        .ack      (ack),
        .level    (level),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             level;
        logic [CNT_W-1:0] pending;
        logic             overflow;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: a request is either idle, in its one-cycle gap, or high
    // with an age counting its high cycles; queued events live in m_pend.
    int m_busy = 0;
    int m_gap  = 0;
    int m_age  = 0;
    int m_pend = 0;
    int m_lost = 0;

    task automatic add_event(input logic p);
        if (p) begin
            if (m_pend == PMAX) m_lost = 1;
            else                m_pend = m_pend + 1;
        end
    endtask

    task automatic model_step(input logic p, input logic a, input logic r);
        if (!r) begin
            m_busy = 0; m_gap = 0; m_age = 0; m_pend = 0; m_lost = 0;
        end else if (m_busy == 0) begin
            if (p) begin
                m_busy = 1;
                m_age  = 1;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
            m_age = 1;
            add_event(p);
        end else if (a && (m_age >= MIN_HIGH)) begin
            if (m_pend + int'(p) > 0) begin
                m_gap  = 1;
                m_pend = m_pend + int'(p) - 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_age = m_age + 1;
            add_event(p);
        end
    endtask

    task automatic drive(input logic p, input logic a, input logic r);
        exp_t e;
        pulse = p;
        ack   = a;
        reset = r;
        @(posedge clk);
        model_step(p, a, r);
        e.level    = (m_busy != 0) && (m_gap == 0);
        e.pending  = CNT_W'(m_pend);
        e.overflow = (m_lost != 0);
        sb.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            total = total + 3;
            if (level !== e_mon.level) begin
                bad = bad + 1;
                $display("FAIL level cyc=%0d got=%0b want=%0b", cyc, level, e_mon.level);
            end
            if (pending !== e_mon.pending) begin
                bad = bad + 1;
                $display("FAIL pending cyc=%0d got=%0d want=%0d", cyc, pending, e_mon.pending);
            end
            if (overflow !== e_mon.overflow) begin
                bad = bad + 1;
                $display("FAIL overflow cyc=%0d got=%0b want=%0b", cyc, overflow, e_mon.overflow);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // single event, ack held high
        drive(1'b1, 1'b1, 1'b1);
        repeat (8) drive(1'b0, 1'b1, 1'b1);

        // late ack, with a stray ack during the minimum-high window
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, (i == 1), 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b1);

        // three queued events, ack held high
        for (int i = 0; i < 20; i++) drive((i == 0) || (i == 2) || (i == 3), 1'b1, 1'b1);

        // saturation with ack low, then reset mid-request
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (8) drive(1'b0, 1'b1, 1'b1);

        // simultaneous consume: pending=1 in WAIT_ACK, ack and pulse together
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        repeat (15) drive(1'b0, 1'b1, 1'b1);

        // randomized traffic with rare resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 199) != 0));
        end

        @(negedge clk);
        #1;
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
